// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder slice: FSM state encoding,
// word width, lane count and the natural-alignment rule used by the optional
// alignment check (MEM_RESPONDER_ALIGN_CHECK_EN).
package mem_responder_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_LANES = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // 1 when the access does not fit a naturally aligned pattern for its offset.
  function automatic logic align_bad(input logic       we,
                                     input logic [1:0] offset,
                                     input logic [3:0] be);
    logic bad;
    bad = 1'b0;
    if (!we) begin
      bad = (offset != 2'd0);
    end else begin
      case (offset)
        2'd0:    bad = 1'b0;
        2'd1:    bad = (be != 4'b0010);
        2'd2:    bad = (be != 4'b1100);
        default: bad = (be != 4'b1000);
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port word storage with per-byte-lane write enables and a registered
// read port. Read-during-write returns the old word. Contents are not reset.
module mem_responder_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic [DATA_W/8-1:0] we,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes and synchronous read of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store request, waits
// LATENCY cycles, commits against internal storage and returns a response.
// Optional alignment checking is compiled in with MEM_RESPONDER_ALIGN_CHECK_EN.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where
// resp_valid and resp_ready are both 1. Neither ready depends on its valid.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = mem_responder_pkg::DATA_W,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(DEPTH);

  state_t            state, state_next;
  logic [3:0]        count;
  logic              lat_we;
  logic [AW-1:0]     lat_idx;
  logic [3:0]        lat_be;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_bad;
  logic              bad_now;
  logic              accept;
  logic              commit;
  logic [AW-1:0]     ram_addr;
  logic [3:0]        ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[ADDR_W-1:AW+2], req_addr[1:0]};

  assign accept = req_valid && req_ready;
  assign commit = (state == BUSY) && (count == 4'd0);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign bad_now = align_bad(req_we, req_addr[1:0], req_be);
`else
  assign bad_now = 1'b0;
`endif

  // While idle the RAM reads the incoming address so the word is ready by
  // commit even at LATENCY=1; afterwards it keeps reading the latched word.
  assign ram_addr = (state == IDLE) ? req_addr[AW+1:2] : lat_idx;
  assign ram_we   = (commit && lat_we && !lat_bad) ? lat_be : 4'b0000;

  mem_responder_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (lat_wdata),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (count == 4'd0) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  // Request latch and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 4'd0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_be    <= 4'b0000;
      lat_wdata <= '0;
      lat_bad   <= 1'b0;
    end else if (accept) begin
      count     <= 4'(LATENCY - 1);
      lat_we    <= req_we;
      lat_idx   <= req_addr[AW+1:2];
      lat_be    <= req_be;
      lat_wdata <= req_wdata;
      lat_bad   <= bad_now;
    end else if (state == BUSY && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  // Response data captured at commit; stores and flagged accesses return 0.
  always_ff @(posedge clk) begin
    if (rst)         resp_rdata <= '0;
    else if (commit) resp_rdata <= (lat_we || lat_bad) ? '0 : ram_rdata;
  end

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  // Error flag captured at commit and held through the response phase.
  always_ff @(posedge clk) begin
    if (rst)         resp_err <= 1'b0;
    else if (commit) resp_err <= lat_bad;
  end
`else
  assign resp_err = 1'b0;
`endif

endmodule
